// File: rtl/verinject_injection_sequencer_if.sv
// ============================================================================
// Module   : verinject_injection_sequencer_if
// Purpose  : Command port bundle for the injection sequencer. A producer
//            offers one timestamped command per cycle with a valid/ready
//            handshake; the sequencer accepts it when it has FIFO space.
// Signals  : cmd_valid  master->slave  command offered
//            cmd_ready  slave->master  sequencer can accept (FIFO not full)
//            cmd_op     master->slave  0 INJECT, 1 CLEAR, 2 FLUSH, 3 reserved
//            cmd_cycle  master->slave  absolute cycle_count value to emit at
//            cmd_bit    master->slave  target bit index (INJECT only)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface verinject_injection_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_cycle;
  logic [31:0] cmd_bit;

  modport master (output cmd_valid, output cmd_op, output cmd_cycle, output cmd_bit,
                  input  cmd_ready);
  modport slave  (input  cmd_valid, input  cmd_op, input  cmd_cycle, input  cmd_bit,
                  output cmd_ready);
endinterface

`default_nettype wire

// File: rtl/verinject_injection_sequencer.sv
// ============================================================================
// Module   : verinject_injection_sequencer
// Purpose  : Drives the shared 32-bit verinject__injector_state bus. Commands
//            are queued in a FIFO and each one is emitted as a single-cycle
//            bus code when the free-running cycle counter reaches its
//            timestamp. Codes: 32'hFFFF_FFFF idle, 32'hFFFF_FFFE clear all,
//            0..BIT_COUNT-1 toggle that bit.
// Ports    : clock, reset_n (async, active-low)
//            cmd                       command handshake (slave modport)
//            verinject__injector_state registered bus code
//            cycle_count               free-running cycle counter
//            busy                      FIFO non-empty or emission pending
//            fired_count               emitted codes, saturating
//            err_sticky                dropped/illegal command seen
//            rand_en, rand_period      only with VERINJECT_SEQ_LFSR_EN
// Options  : VERINJECT_SEQ_LFSR_EN - adds an LFSR-driven random injector that
//            runs only while the FSM is idle and the FIFO is empty.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module verinject_injection_sequencer #(
  parameter int DEPTH     = 4,
  parameter int BIT_COUNT = 1024
) (
  input  logic                           clock,
  input  logic                           reset_n,
  verinject_injection_sequencer_if.slave cmd,
`ifdef VERINJECT_SEQ_LFSR_EN
  input  logic                           rand_en,
  input  logic [15:0]                    rand_period,
`endif
  output logic [31:0]                    verinject__injector_state,
  output logic [31:0]                    cycle_count,
  output logic                           busy,
  output logic [15:0]                    fired_count,
  output logic                           err_sticky
);

  localparam int          c_AW        = $clog2(DEPTH);
  localparam logic [31:0] c_BIT_LIMIT = 32'(BIT_COUNT);
  localparam logic [31:0] c_CODE_IDLE = 32'hFFFF_FFFF;
  localparam logic [31:0] c_CODE_CLR  = 32'hFFFF_FFFE;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_FIRE  = 2'd2
  } state_t;

  typedef struct packed {
    logic        is_clear;
    logic [31:0] cycle;
    logic [31:0] bit_idx;
  } entry_t;

  entry_t      r_fifo [DEPTH];
  logic [c_AW:0] r_wr_ptr;
  logic [c_AW:0] r_rd_ptr;
  state_t      r_state;
  logic [31:0] r_bus;
  logic [31:0] r_cycle_count;
  logic [15:0] r_fired;
  logic        r_err;

  logic        w_empty;
  logic        w_full;
  entry_t      w_head;
  logic        w_accept;
  logic        w_bad;
  logic        w_push;
  logic        w_flush;
  logic        w_due;
  logic        w_fire;
  logic [31:0] w_count_next;
  logic [15:0] w_fired_inc;

  assign w_empty  = (r_wr_ptr == r_rd_ptr);
  assign w_full   = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                    (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
  assign w_head   = r_fifo[r_rd_ptr[c_AW-1:0]];

  // Ready is purely a function of FIFO occupancy; a pop in the same cycle
  // does not open a slot early.
  assign cmd.cmd_ready = ~w_full;
  assign w_accept = cmd.cmd_valid & ~w_full;
  assign w_bad    = (cmd.cmd_op == 2'd3) ||
                    ((cmd.cmd_op == 2'd0) && (cmd.cmd_bit >= c_BIT_LIMIT));
  assign w_push   = w_accept && ~w_bad && ((cmd.cmd_op == 2'd0) || (cmd.cmd_op == 2'd1));
  assign w_flush  = w_accept && (cmd.cmd_op == 2'd2);

  // The bus code is registered, so it appears alongside the next counter
  // value. Comparing against that value makes the code visible in exactly
  // the cycle whose cycle_count equals the timestamp. Plain unsigned compare:
  // stale timestamps fire at once.
  assign w_count_next = r_cycle_count + 32'd1;
  assign w_due        = ~w_empty && (w_count_next >= w_head.cycle);
  // FIRE may chain straight into another FIRE so due entries go out on
  // consecutive cycles.
  assign w_fire       = ((r_state == ST_ARMED) || (r_state == ST_FIRE)) && w_due;
  assign w_fired_inc  = (r_fired == 16'hFFFF) ? r_fired : r_fired + 16'd1;

  // Payload storage needs no reset; occupancy lives in the pointers.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_fifo[r_wr_ptr[c_AW-1:0]] <= '{is_clear: (cmd.cmd_op == 2'd1),
                                      cycle:    cmd.cmd_cycle,
                                      bit_idx:  cmd.cmd_bit};
    end
  end

`ifdef VERINJECT_SEQ_LFSR_EN
  localparam logic [31:0] c_LFSR_SEED = 32'hACE1_2468;
  localparam logic [31:0] c_LFSR_TAPS = 32'h8020_0003;
  logic [31:0] r_lfsr;
  logic [15:0] r_period_cnt;
  logic        w_rand_active;
  assign w_rand_active = (r_state == ST_IDLE) && w_empty && rand_en && (rand_period != 16'd0);
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_bus         <= c_CODE_IDLE;
      r_cycle_count <= 32'd0;
      r_fired       <= 16'd0;
      r_err         <= 1'b0;
`ifdef VERINJECT_SEQ_LFSR_EN
      r_lfsr        <= c_LFSR_SEED;
      r_period_cnt  <= 16'd0;
`endif
    end else begin
      r_cycle_count <= w_count_next;
      r_bus         <= c_CODE_IDLE;
      if (w_accept && w_bad) begin
        r_err <= 1'b1;
      end

      // FLUSH discards everything; a head firing this same edge has already
      // been read out onto the bus, so only the remaining entries are lost.
      if (w_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_fire) r_rd_ptr <= r_rd_ptr + 1'b1;
      end

      if (w_fire) begin
        r_bus   <= w_head.is_clear ? c_CODE_CLR : w_head.bit_idx;
        r_fired <= w_fired_inc;
        r_state <= ST_FIRE;
      end else if (~w_empty && ~w_flush) begin
        r_state <= ST_ARMED;
      end else begin
        r_state <= ST_IDLE;
      end

`ifdef VERINJECT_SEQ_LFSR_EN
      r_lfsr <= {1'b0, r_lfsr[31:1]} ^ (r_lfsr[0] ? c_LFSR_TAPS : 32'd0);
      if (w_rand_active) begin
        if (r_period_cnt == rand_period - 16'd1) begin
          r_period_cnt <= 16'd0;
          // Out-of-range samples are skipped silently.
          if (r_lfsr < c_BIT_LIMIT) begin
            r_bus   <= r_lfsr;
            r_fired <= w_fired_inc;
          end
        end else begin
          r_period_cnt <= r_period_cnt + 16'd1;
        end
      end else begin
        r_period_cnt <= 16'd0;
      end
`endif
    end
  end

  assign verinject__injector_state = r_bus;
  assign cycle_count               = r_cycle_count;
  assign fired_count               = r_fired;
  assign err_sticky                = r_err;
  assign busy                      = (r_state != ST_IDLE) | ~w_empty;

endmodule

`default_nettype wire
